// File: rtl/launcher_pkg.sv
// Shared state encoding and default timing for the core launcher.
package launcher_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CRST,
      START,
      RUN,
      RESULT
   } state_t;

   localparam int unsigned DEF_RESET_CYCLES = 4;
   localparam int unsigned DEF_START_CYCLES = 2;
   localparam int unsigned DEF_TIMEOUT      = 5000;
   localparam int unsigned DEF_CNT_W        = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   // Clear has priority over count; count stops at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/core_launcher.sv
// Start/ack handshake initiator: parks the core in reset, pulses start,
// times the run until ack or timeout, and hands the result to the host.
module core_launcher
   import launcher_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int unsigned START_CYCLES = DEF_START_CYCLES,
   parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             launch_valid,
   input  logic [1:0]       launch_prog,
   output logic             launch_ready,
   output logic             core_reset,
   output logic             core_start,
   output logic [1:0]       core_prog,
   input  logic             core_ack,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_cycles,
   output logic             res_timeout
);

   state_t             state;
   state_t             state_nx;
   logic               cnt_clr;
   logic               cnt_en;
   logic [CNT_W-1:0]   phase_cnt;

   logic               ready_nx;
   logic               crst_nx;
   logic               start_nx;
   logic [1:0]         prog_nx;
   logic               valid_nx;
   logic [CNT_W-1:0]   cycles_nx;
   logic               timeout_nx;

   // One counter serves every phase: it is cleared on each phase change, so
   // in RUN it holds the cycles elapsed since core_start fell.
   sat_counter #(
      .CNT_W(CNT_W)
   ) u_phase_cnt (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .count  (phase_cnt)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, counter control and next value of every registered output.
   always_comb begin
      state_nx   = state;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      ready_nx   = launch_ready;
      crst_nx    = core_reset;
      start_nx   = core_start;
      prog_nx    = core_prog;
      valid_nx   = res_valid;
      cycles_nx  = res_cycles;
      timeout_nx = res_timeout;
      case (state)
         IDLE: begin
            if (launch_valid && launch_ready) begin
               state_nx = CRST;
               ready_nx = 1'b0;
               prog_nx  = launch_prog;
               cnt_clr  = 1'b1;
            end
         end
         CRST: begin
            if (phase_cnt == CNT_W'(RESET_CYCLES - 1)) begin
               state_nx = START;
               crst_nx  = 1'b0;
               start_nx = 1'b1;
               cnt_clr  = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         START: begin
            if (phase_cnt == CNT_W'(START_CYCLES - 1)) begin
               state_nx = RUN;
               start_nx = 1'b0;
               cnt_clr  = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         RUN: begin
            // Ack is tested first so it wins over a coincident timeout.
            if (core_ack) begin
               state_nx   = RESULT;
               valid_nx   = 1'b1;
               cycles_nx  = phase_cnt;
               timeout_nx = 1'b0;
               cnt_clr    = 1'b1;
            end else if (phase_cnt == CNT_W'(TIMEOUT - 1)) begin
               state_nx   = RESULT;
               valid_nx   = 1'b1;
               cycles_nx  = CNT_W'(TIMEOUT);
               timeout_nx = 1'b1;
               cnt_clr    = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         RESULT: begin
            if (res_ready) begin
               state_nx = IDLE;
               valid_nx = 1'b0;
               crst_nx  = 1'b1;
               ready_nx = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Output registers; nothing reaches an output combinationally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         launch_ready <= 1'b1;
         core_reset   <= 1'b1;
         core_start   <= 1'b0;
         core_prog    <= '0;
         res_valid    <= 1'b0;
         res_cycles   <= '0;
         res_timeout  <= 1'b0;
      end else begin
         launch_ready <= ready_nx;
         core_reset   <= crst_nx;
         core_start   <= start_nx;
         core_prog    <= prog_nx;
         res_valid    <= valid_nx;
         res_cycles   <= cycles_nx;
         res_timeout  <= timeout_nx;
      end
   end

endmodule
